mor1kx_store_buffer_drain: RTL and testbench
============================================

MOR1KX_STORE_BUFFER_DRAIN -- requirements
Module: mor1kx_store_buffer_drain

Interface
REQ-001 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, meaning the address and data width.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: sb_adr_i, sb_dat_i, sb_pc_i  in  OPTION_OPERAND_WIDTH each  store-buffer head entry fields.
REQ-004 SHALL have ports: sb_bsel_i  in  OPTION_OPERAND_WIDTH/8  byte select; sb_atomic_i  in  1  atomic store flag; sb_empty_i  in  1  store buffer empty.
REQ-005 SHALL have port sb_read_o  out  1  one-cycle pop strobe to the store buffer.
REQ-006 SHALL have ports: dbus_adr_o, dbus_dat_o  out  OPTION_OPERAND_WIDTH; dbus_bsel_o  out  OPTION_OPERAND_WIDTH/8; dbus_req_o  out  1; dbus_we_o  out  1.
REQ-007 SHALL have ports: dbus_ack_i  in  1  write done; dbus_err_i  in  1  bus error.
REQ-008 SHALL have ports: atomic_reserve_i  in  1  reservation still valid; atomic_flag_o  out  1  store-conditional result pulse; atomic_flag_valid_o  out  1.
REQ-009 SHALL have ports: store_err_o  out  1  sticky error; store_err_pc_o, store_err_adr_o  out  OPTION_OPERAND_WIDTH; err_clear_i  in  1; idle_o  out  1.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, WRITE, ERROR.
REQ-011 In IDLE with sb_empty_i=0, SHALL assert sb_read_o for exactly one cycle and go to FETCH.
REQ-012 In FETCH, SHALL register sb_* fields (store buffer read data valid one cycle after pop) into internal entry registers.
REQ-013 From FETCH: atomic entry with atomic_reserve_i=0 -> pulse atomic_flag_valid_o with atomic_flag_o=0, no bus request, return to IDLE; otherwise go to WRITE.
REQ-014 In WRITE, SHALL hold dbus_req_o=1, dbus_we_o=1, dbus_adr_o/dat_o/bsel_o stable from the registered entry until dbus_ack_i or dbus_err_i.
REQ-015 On dbus_ack_i in WRITE: deassert dbus_req_o the next cycle; if the entry is atomic, pulse atomic_flag_valid_o=1 with atomic_flag_o=1.
REQ-016 On ack, if sb_empty_i=0, SHALL assert sb_read_o in the same cycle and go directly to FETCH (back-to-back, 2-cycle minimum per store with zero-wait bus); else go to IDLE.
REQ-017 On dbus_err_i in WRITE: set store_err_o=1, capture store_err_pc_o/store_err_adr_o from the entry, go to ERROR; no further pops.
REQ-018 In ERROR, SHALL hold until err_clear_i=1, then clear store_err_o and go to IDLE next cycle.
REQ-019 If dbus_ack_i and dbus_err_i coincide, error SHALL take priority.
REQ-020 dbus_ack_i/dbus_err_i outside WRITE SHALL be ignored.
REQ-021 sb_read_o SHALL never assert when sb_empty_i=1 or in ERROR.
REQ-022 idle_o SHALL be 1 only in IDLE with sb_empty_i=1.
REQ-023 Atomic pulses SHALL be exactly one cycle wide.

Reset
REQ-024 On rst: state=IDLE; sb_read_o, dbus_req_o, dbus_we_o, atomic_flag_o, atomic_flag_valid_o, store_err_o = 0; all address/data/pc/bsel outputs = 0.
REQ-025 Reset mid-WRITE SHALL drop dbus_req_o immediately; the in-flight entry is discarded.

Structure
REQ-026 FSM state encodings SHALL be localparams in a shared defines file alongside existing mor1kx defines.
REQ-027 Single flat module; no sub-module required; instantiated downstream of mor1kx_store_buffer.

Verification
REQ-028 One store adr=0x100 dat=0xDEADBEEF bsel=0xF, ack after 3 cycles -> single pop, req held 3+ cycles, dbus outputs match, then idle_o=1.
REQ-029 Four queued stores, zero-wait ack -> four pops, one write every 2 cycles, in FIFO order.
REQ-030 Atomic store with atomic_reserve_i=0 -> no dbus_req_o, atomic_flag_valid_o=1/atomic_flag_o=0 for one cycle.
REQ-031 Atomic store with atomic_reserve_i=1, ack -> write issued, atomic_flag_o=1 pulse.
REQ-032 dbus_err_i on store pc=0x2000 adr=0x40 with 2 more queued -> store_err_o=1, err pc/adr captured, no pops until err_clear_i, then remaining 2 drained.
REQ-033 rst asserted during WRITE -> all outputs 0 next edge, state IDLE.

Source files
------------

// File: rtl/mor1kx_store_buffer_drain_pkg.sv
// Shared definitions for the store-buffer drain controller.
// The state encodings are plain localparams so other mor1kx blocks can use
// them without the enum type. The enum below is built from those values.
package mor1kx_store_buffer_drain_pkg;

    localparam logic [1:0] SBD_STATE_IDLE  = 2'd0;
    localparam logic [1:0] SBD_STATE_FETCH = 2'd1;
    localparam logic [1:0] SBD_STATE_WRITE = 2'd2;
    localparam logic [1:0] SBD_STATE_ERROR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = SBD_STATE_IDLE,
        S_FETCH = SBD_STATE_FETCH,
        S_WRITE = SBD_STATE_WRITE,
        S_ERROR = SBD_STATE_ERROR
    } sbd_state_t;

endpackage

// File: rtl/mor1kx_store_buffer_drain.sv
// Store-buffer drain controller.
// Pops the head entry of the store buffer, registers it, and presents it as
// a single write on the data bus. Atomic stores whose reservation has been
// lost are retired without touching the bus, and only a failed
// store-conditional result is reported for them. A bus error parks the
// controller in ERROR with the faulting pc/address captured until software
// clears it.
//
// state | meaning
// IDLE  | waiting for the store buffer to become non-empty; pops on entry
// FETCH | popped entry's data is valid; capture it and decide the next step
// WRITE | bus write outstanding; waits for ack or err
// ERROR | sticky bus error reported; no pops until err_clear_i
module mor1kx_store_buffer_drain
    import mor1kx_store_buffer_drain_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    input  logic                              sb_atomic_i,
    input  logic                              sb_empty_i,
    output logic                              sb_read_o,

    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
    output logic                              dbus_req_o,
    output logic                              dbus_we_o,
    input  logic                              dbus_ack_i,
    input  logic                              dbus_err_i,

    input  logic                              atomic_reserve_i,
    output logic                              atomic_flag_o,
    output logic                              atomic_flag_valid_o,

    output logic                              store_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_adr_o,
    input  logic                              err_clear_i,
    output logic                              idle_o
);

    sbd_state_t                      state;
    logic [OPTION_OPERAND_WIDTH-1:0] entry_pc;
    logic                            entry_atomic;
    logic                            write_done;

    // A clean ack (error has priority) retires the current write.
    assign write_done = (state == S_WRITE) && dbus_ack_i && !dbus_err_i;

    // The pop strobe is decoded from the current state and sb_empty_i rather
    // than registered, so it can never fire against an already-empty buffer
    // and the next pop can share the ack cycle for back-to-back draining.
    assign sb_read_o = !sb_empty_i && ((state == S_IDLE) || write_done);

    // Nothing queued and nothing in flight.
    assign idle_o = (state == S_IDLE) && sb_empty_i;

    // Main sequencer: state, registered bus outputs, atomic result pulse and
    // the sticky error record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            dbus_adr_o          <= '0;
            dbus_dat_o          <= '0;
            dbus_bsel_o         <= '0;
            dbus_req_o          <= 1'b0;
            dbus_we_o           <= 1'b0;
            entry_pc            <= '0;
            entry_atomic        <= 1'b0;
            atomic_flag_o       <= 1'b0;
            atomic_flag_valid_o <= 1'b0;
            store_err_o         <= 1'b0;
            store_err_pc_o      <= '0;
            store_err_adr_o     <= '0;
        end else begin
            // Atomic result is a single-cycle pulse unless re-armed below.
            atomic_flag_o       <= 1'b0;
            atomic_flag_valid_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!sb_empty_i) begin
                        state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    dbus_adr_o   <= sb_adr_i;
                    dbus_dat_o   <= sb_dat_i;
                    dbus_bsel_o  <= sb_bsel_i;
                    entry_pc     <= sb_pc_i;
                    entry_atomic <= sb_atomic_i;
                    if (sb_atomic_i && !atomic_reserve_i) begin
                        // Reservation lost: store-conditional fails, no write.
                        atomic_flag_valid_o <= 1'b1;
                        atomic_flag_o       <= 1'b0;
                        state               <= S_IDLE;
                    end else begin
                        dbus_req_o <= 1'b1;
                        dbus_we_o  <= 1'b1;
                        state      <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (dbus_err_i) begin
                        dbus_req_o      <= 1'b0;
                        dbus_we_o       <= 1'b0;
                        store_err_o     <= 1'b1;
                        store_err_pc_o  <= entry_pc;
                        store_err_adr_o <= dbus_adr_o;
                        state           <= S_ERROR;
                    end else if (dbus_ack_i) begin
                        dbus_req_o <= 1'b0;
                        dbus_we_o  <= 1'b0;
                        if (entry_atomic) begin
                            atomic_flag_valid_o <= 1'b1;
                            atomic_flag_o       <= 1'b1;
                        end
                        // sb_read_o already popped the next entry this cycle.
                        state <= sb_empty_i ? S_IDLE : S_FETCH;
                    end
                end

                S_ERROR: begin
                    if (err_clear_i) begin
                        store_err_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mor1kx_store_buffer_drain.sv
// Self-checking bench for mor1kx_store_buffer_drain.
// A store buffer (queue) and a bus responder with configurable latency
// surround the DUT. The reference model is a list of the writes that must
// appear on the bus, in push order, plus a list of expected store-conditional
// results; both are derived when a store is pushed.
module tb_mor1kx_store_buffer_drain;

    localparam int W  = 32;
    localparam int BW = W / 8;

    typedef struct {
        logic [W-1:0]  adr;
        logic [W-1:0]  dat;
        logic [W-1:0]  pc;
        logic [BW-1:0] bsel;
        logic          atomic;
    } st_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  sb_adr, sb_dat, sb_pc;
    logic [BW-1:0] sb_bsel;
    logic          sb_atomic, sb_empty, sb_read;
    logic [W-1:0]  dbus_adr, dbus_dat;
    logic [BW-1:0] dbus_bsel;
    logic          dbus_req, dbus_we, dbus_ack, dbus_err;
    logic          reserve, atomic_flag, atomic_flag_valid;
    logic          store_err, err_clear, idle;
    logic [W-1:0]  store_err_pc, store_err_adr;

    mor1kx_store_buffer_drain #(.OPTION_OPERAND_WIDTH(W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .sb_adr_i            (sb_adr),
        .sb_dat_i            (sb_dat),
        .sb_pc_i             (sb_pc),
        .sb_bsel_i           (sb_bsel),
        .sb_atomic_i         (sb_atomic),
        .sb_empty_i          (sb_empty),
        .sb_read_o           (sb_read),
        .dbus_adr_o          (dbus_adr),
        .dbus_dat_o          (dbus_dat),
        .dbus_bsel_o         (dbus_bsel),
        .dbus_req_o          (dbus_req),
        .dbus_we_o           (dbus_we),
        .dbus_ack_i          (dbus_ack),
        .dbus_err_i          (dbus_err),
        .atomic_reserve_i    (reserve),
        .atomic_flag_o       (atomic_flag),
        .atomic_flag_valid_o (atomic_flag_valid),
        .store_err_o         (store_err),
        .store_err_pc_o      (store_err_pc),
        .store_err_adr_o     (store_err_adr),
        .err_clear_i         (err_clear),
        .idle_o              (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    st_t   sbq[$];      // store buffer contents
    st_t   exp_q[$];    // writes still expected on the bus, in order
    logic  atom_q[$];   // expected store-conditional results, in order
    int    ack_cycles[$];

    logic  pop_pending = 1'b0;
    logic  req_prev = 1'b0;
    logic  prev_valid = 1'b0;
    int    cyc = 0;
    int    pops = 0;
    int    writes_seen = 0;
    int    wait_cnt = 0;
    int    lat = 0;
    int    lat_min = 0;
    int    lat_max = 0;
    int    req_len = 0;
    int    last_req_len = 0;
    logic  spur_en = 1'b0;
    logic  err_en = 1'b0;
    logic [W-1:0]  err_adr = '0;
    logic [W-1:0]  held_adr, held_dat;
    logic [BW-1:0] held_bsel;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push a store into the buffer and derive its expected outcome.
    task automatic push(input st_t s);
        sbq.push_back(s);
        if (!(s.atomic && !reserve)) exp_q.push_back(s);
        if (s.atomic) atom_q.push_back(reserve);
    endtask

    task automatic push_rand();
        st_t s;
        s.adr    = {$urandom_range(32'h3fff_ffff, 0), 2'b00};
        s.dat    = $urandom;
        s.pc     = {$urandom_range(32'h3fff_ffff, 0), 2'b00};
        s.bsel   = BW'($urandom_range(15, 1));
        s.atomic = ($urandom_range(3, 0) == 0);
        push(s);
    endtask

    // One clock: observe registered outputs, model the store buffer and the
    // bus responder, then look at the pop strobe the DUT will present.
    task automatic tick();
        st_t cur;
        @(posedge clk);
        #1;
        cyc++;

        if (pop_pending) begin
            chk("pop_has_data", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                cur       = sbq.pop_front();
                sb_adr    = cur.adr;
                sb_dat    = cur.dat;
                sb_pc     = cur.pc;
                sb_bsel   = cur.bsel;
                sb_atomic = cur.atomic;
            end
            pops++;
        end

        chk("flag_without_valid", atomic_flag & ~atomic_flag_valid, 0);
        if (atomic_flag_valid) begin
            chk("atomic_pulse_width", prev_valid, 0);
            chk("atomic_result_expected", atom_q.size() != 0, 1);
            if (atom_q.size() != 0) chk("atomic_result", atomic_flag, atom_q.pop_front());
        end
        prev_valid = atomic_flag_valid;

        dbus_ack = 1'b0;
        dbus_err = 1'b0;
        if (dbus_req) begin
            if (!req_prev) begin
                req_len  = 0;
                wait_cnt = 0;
                lat      = $urandom_range(lat_max, lat_min);
                writes_seen++;
                chk("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q[0];
                    chk("wr_adr", dbus_adr, cur.adr);
                    chk("wr_dat", dbus_dat, cur.dat);
                    chk("wr_bsel", dbus_bsel, cur.bsel);
                end
                chk("wr_we", dbus_we, 1);
                held_adr  = dbus_adr;
                held_dat  = dbus_dat;
                held_bsel = dbus_bsel;
            end else begin
                chk("hold_adr", dbus_adr, held_adr);
                chk("hold_dat", dbus_dat, held_dat);
                chk("hold_bsel", dbus_bsel, held_bsel);
                chk("hold_we", dbus_we, 1);
            end
            req_len++;
            if (wait_cnt == lat) begin
                if (err_en && dbus_adr == err_adr) begin
                    dbus_err = 1'b1;
                    dbus_ack = 1'($urandom_range(1, 0));
                end else begin
                    dbus_ack = 1'b1;
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                ack_cycles.push_back(cyc);
                last_req_len = req_len;
            end
            wait_cnt++;
        end else if (spur_en) begin
            dbus_ack = 1'($urandom_range(1, 0));
            dbus_err = 1'($urandom_range(1, 0));
        end
        req_prev = dbus_req;

        sb_empty = (sbq.size() == 0);
        #1;
        chk("pop_when_empty", sb_read & sb_empty, 0);
        chk("pop_in_error", sb_read & store_err, 0);
        pop_pending = sb_read;
    endtask

    task automatic drain(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            done = (sbq.size() == 0) && (exp_q.size() == 0) && (atom_q.size() == 0)
                   && !pop_pending && idle;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        st_t s;
        int  pops0, writes0;
        logic seen;

        rst = 1'b1;
        sb_adr = '0; sb_dat = '0; sb_pc = '0; sb_bsel = '0; sb_atomic = 1'b0;
        sb_empty = 1'b1; dbus_ack = 1'b0; dbus_err = 1'b0;
        reserve = 1'b1; err_clear = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req", dbus_req, 0);
        chk("rst_we", dbus_we, 0);
        chk("rst_read", sb_read, 0);
        chk("rst_adr", dbus_adr, 0);
        chk("rst_dat", dbus_dat, 0);
        chk("rst_bsel", dbus_bsel, 0);
        chk("rst_flag", {atomic_flag, atomic_flag_valid}, 0);
        chk("rst_err", store_err, 0);
        chk("rst_err_pc", store_err_pc, 0);
        chk("rst_err_adr", store_err_adr, 0);
        chk("rst_idle", idle, 1);
        rst = 1'b0;

        // Single store, ack on the third request cycle
        lat_min = 2; lat_max = 2;
        s = '{adr: 32'h100, dat: 32'hDEADBEEF, pc: 32'h1000, bsel: 4'hF, atomic: 1'b0};
        push(s);
        drain("single_drain");
        chk("single_pops", pops, 1);
        chk("single_writes", writes_seen, 1);
        chk("single_req_hold", last_req_len >= 3, 1);
        chk("single_idle", idle, 1);

        // Four queued stores, zero-wait bus
        lat_min = 0; lat_max = 0;
        ack_cycles.delete();
        pops0 = pops;
        for (int i = 0; i < 4; i++) begin
            s = '{adr: 32'h200 + 32'(i * 4), dat: 32'hA000 + 32'(i), pc: 32'h3000 + 32'(i * 4),
                  bsel: 4'hF, atomic: 1'b0};
            push(s);
        end
        drain("fifo_drain");
        chk("fifo_pops", pops - pops0, 4);
        chk("fifo_acks", ack_cycles.size(), 4);
        if (ack_cycles.size() == 4)
            for (int i = 1; i < 4; i++) chk("fifo_spacing", ack_cycles[i] - ack_cycles[i-1], 2);

        // Atomic store with reservation lost: no bus write
        reserve = 1'b0;
        writes0 = writes_seen;
        s = '{adr: 32'h300, dat: 32'h5555, pc: 32'h4000, bsel: 4'h3, atomic: 1'b1};
        push(s);
        drain("atomic_fail_drain");
        chk("atomic_fail_no_write", writes_seen - writes0, 0);

        // Atomic store with reservation held: write then success pulse
        reserve = 1'b1;
        lat_min = 1; lat_max = 1;
        writes0 = writes_seen;
        s = '{adr: 32'h304, dat: 32'h6666, pc: 32'h4004, bsel: 4'hC, atomic: 1'b1};
        push(s);
        drain("atomic_ok_drain");
        chk("atomic_ok_write", writes_seen - writes0, 1);

        // Bus error with two stores queued behind it
        err_en = 1'b1; err_adr = 32'h40;
        lat_min = 1; lat_max = 1;
        pops0 = pops;
        push('{adr: 32'h40,  dat: 32'h1111, pc: 32'h2000, bsel: 4'hF, atomic: 1'b0});
        push('{adr: 32'h44,  dat: 32'h2222, pc: 32'h2004, bsel: 4'hF, atomic: 1'b0});
        push('{adr: 32'h48,  dat: 32'h3333, pc: 32'h2008, bsel: 4'hF, atomic: 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = store_err;
        end
        chk("err_seen", seen, 1);
        chk("err_pc", store_err_pc, 32'h2000);
        chk("err_adr", store_err_adr, 32'h40);
        repeat (10) tick();
        chk("err_no_pops", pops - pops0, 1);
        chk("err_sticky", store_err, 1);
        chk("err_not_idle", idle, 0);
        err_en = 1'b0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", store_err, 0);
        drain("err_drain");
        chk("err_total_pops", pops - pops0, 3);

        // Randomised traffic with random latency and spurious ack/err
        lat_min = 0; lat_max = 3;
        spur_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            reserve = 1'($urandom_range(1, 0));
            for (int r = 0; r < 3; r++) begin
                for (int k = $urandom_range(4, 1); k > 0; k--) push_rand();
                for (int t = $urandom_range(6, 0); t > 0; t--) tick();
            end
            drain("rand_drain");
            chk("rand_no_err", store_err, 0);
        end
        spur_en = 1'b0;

        // Reset while a write is outstanding
        lat_min = 10; lat_max = 10;
        push('{adr: 32'h500, dat: 32'h7777, pc: 32'h5000, bsel: 4'hF, atomic: 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = dbus_req;
        end
        chk("mid_write_req_seen", seen, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_req", dbus_req, 0);
        chk("rst_mid_we", dbus_we, 0);
        chk("rst_mid_adr", dbus_adr, 0);
        chk("rst_mid_dat", dbus_dat, 0);
        chk("rst_mid_bsel", dbus_bsel, 0);
        sbq.delete(); exp_q.delete(); atom_q.delete();
        pop_pending = 1'b0; req_prev = 1'b0;
        sb_empty = 1'b1; dbus_ack = 1'b0; dbus_err = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_idle", idle, 1);
        chk("rst_mid_req_after", dbus_req, 0);
        chk("rst_mid_read", sb_read, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
